// File: rtl/psum_feeder.sv
// psum_feeder: drains partial sums from the psum SRAM through the SFP column into the output SRAM.
// Optional macro PSUM_FEEDER_CYCCNT_EN adds cyc_cnt, a saturating 16-bit count of busy cycles per job.
module psum_feeder #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_pass,
  input  logic [addr_bw-1:0]     num_out,
  output logic                   sram_cen,
  output logic [addr_bw-1:0]     sram_addr,
  input  logic [psum_bw*col-1:0] sram_rdata,
  output logic [psum_bw*col-1:0] sfp_in,
  output logic                   sfp_i_valid,
  output logic                   sfp_clr,
  input  logic [psum_bw*col-1:0] sfp_out,
  output logic                   out_wen,
  output logic [addr_bw-1:0]     out_addr,
  output logic [psum_bw*col-1:0] out_wdata,
  output logic                   busy,
  output logic                   done
`ifdef PSUM_FEEDER_CYCCNT_EN
  ,
  output logic [15:0]            cyc_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CLR, READ, DRAIN, WRITE, DONE} state_t;

  localparam logic [addr_bw-1:0] AddrOne = addr_bw'(1);

  state_t             state_q, state_d;
  logic [3:0]         num_pass_q, num_pass_d;
  logic [addr_bw-1:0] num_out_q, num_out_d;
  logic [addr_bw-1:0] o_q, o_d;
  logic [3:0]         p_q, p_d;
  logic [addr_bw-1:0] rd_addr_q, rd_addr_d;
  logic [addr_bw-1:0] wr_addr_q, wr_addr_d;
  logic               valid_q, valid_d;
  logic [addr_bw-1:0] o_next;

  assign o_next = o_q + AddrOne;

  // The read address starts at o and steps by num_out per pass, so no multiplier is needed.
  always_comb begin
    state_d    = state_q;
    num_pass_d = num_pass_q;
    num_out_d  = num_out_q;
    o_d        = o_q;
    p_d        = p_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_pass_d = num_pass;
          num_out_d  = num_out;
          o_d        = '0;
          p_d        = '0;
          state_d    = (num_pass == 4'd0 || num_out == '0) ? DONE : CLR;
        end
      end
      CLR: begin
        p_d       = '0;
        rd_addr_d = o_q;
        state_d   = READ;
      end
      READ: begin
        if (p_q == num_pass_q - 4'd1) begin
          state_d = DRAIN;
        end else begin
          p_d       = p_q + 4'd1;
          rd_addr_d = rd_addr_q + num_out_q;
        end
      end
      DRAIN: begin
        wr_addr_d = o_q;
        state_d   = WRITE;
      end
      WRITE: begin
        o_d     = o_next;
        state_d = (o_next < num_out_q) ? CLR : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_pass_q <= '0;
      num_out_q  <= '0;
      o_q        <= '0;
      p_q        <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_pass_q <= num_pass_d;
      num_out_q  <= num_out_d;
      o_q        <= o_d;
      p_q        <= p_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      valid_q    <= valid_d;
    end
  end

  // The SFP strobe trails the read request by one cycle, aligning it with sram_rdata.
  assign valid_d     = (state_q == READ);
  assign sram_cen    = (state_q != READ);
  assign sram_addr   = rd_addr_q;
  assign sfp_in      = sram_rdata;
  assign sfp_i_valid = valid_q;
  assign sfp_clr     = (state_q == CLR);
  assign out_wen     = (state_q == WRITE);
  assign out_addr    = wr_addr_q;
  assign out_wdata   = sfp_out;
  assign busy        = (state_q == CLR) || (state_q == READ) ||
                       (state_q == DRAIN) || (state_q == WRITE);
  assign done        = (state_q == DONE);

`ifdef PSUM_FEEDER_CYCCNT_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        accept;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (accept) begin
      cyc_cnt_d = '0;
    end else if (busy && cyc_cnt_q != 16'hFFFF) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_psum_feeder.sv
// tb_psum_feeder: scoreboard bench for psum_feeder with an SRAM model and an ideal SFP accumulator.
// Expected reads, writes and job completions are queued by stimulus and consumed by the monitor.
module tb_psum_feeder;

  localparam int PsumBw = 16;
  localparam int Col    = 8;
  localparam int AddrBw = 11;
  localparam int W      = PsumBw * Col;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        numPass = '0;
  logic [AddrBw-1:0] numOut = '0;
  logic              sramCen;
  logic [AddrBw-1:0] sramAddr;
  logic [W-1:0]      sramRdata;
  logic [W-1:0]      sfpIn;
  logic              sfpIValid;
  logic              sfpClr;
  logic [W-1:0]      sfpAcc;
  logic              outWen;
  logic [AddrBw-1:0] outAddr;
  logic [W-1:0]      outWdata;
  logic              busy;
  logic              done;
`ifdef PSUM_FEEDER_CYCCNT_EN
  logic [15:0]       cycCnt;
`endif

  psum_feeder #(.psum_bw(PsumBw), .col(Col), .addr_bw(AddrBw)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pass(numPass), .num_out(numOut),
    .sram_cen(sramCen), .sram_addr(sramAddr), .sram_rdata(sramRdata),
    .sfp_in(sfpIn), .sfp_i_valid(sfpIValid), .sfp_clr(sfpClr), .sfp_out(sfpAcc),
    .out_wen(outWen), .out_addr(outAddr), .out_wdata(outWdata),
    .busy(busy), .done(done)
`ifdef PSUM_FEEDER_CYCCNT_EN
    , .cyc_cnt(cycCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AddrBw-1:0] addr;
    logic [W-1:0]      data;
  } wr_t;

  typedef struct {
    int startCycle;
    int lat;
    int nClr;
    int nValid;
    int cyc;
  } job_t;

  logic [AddrBw-1:0] expRd[$];
  wr_t               expWr[$];
  job_t              expJob[$];

  bit dataMode = 1'b0;
  int cycleNum = 0;
  bit endReq = 1'b0;
  bit monDone = 1'b0;
  bit timedOut = 1'b0;
  logic rstPrev = 1'b0;
  int checks = 0;
  int passes = 0;
  int clrCnt = 0;
  int validCnt = 0;

  function automatic logic [W-1:0] memWord(input logic [AddrBw-1:0] a, input bit cm);
    logic [W-1:0] w;
    for (int k = 0; k < Col; k++)
      w[k*PsumBw +: PsumBw] = cm ? 16'd5 : (16'(a) * 16'd16 + 16'(k));
    return w;
  endfunction

  always @(posedge clk) begin
    cycleNum <= cycleNum + 1;
    rstPrev  <= reset;
    if (sramCen === 1'b0) sramRdata <= memWord(sramAddr, dataMode);
  end

  // Ideal SFP column: clear on sfp_clr, lane-wise accumulate on the strobe.
  always @(posedge clk) begin
    if (sfpClr === 1'b1) sfpAcc <= '0;
    else if (sfpIValid === 1'b1)
      for (int k = 0; k < Col; k++)
        sfpAcc[k*PsumBw +: PsumBw] <= sfpAcc[k*PsumBw +: PsumBw] + sfpIn[k*PsumBw +: PsumBw];
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    job_t jb;
    wr_t  wr;
    if (rstPrev) begin
      checkOutput("rst_sram_cen", W'(sramCen), W'(1));
      checkOutput("rst_sfp_i_valid", W'(sfpIValid), W'(0));
      checkOutput("rst_sfp_clr", W'(sfpClr), W'(0));
      checkOutput("rst_out_wen", W'(outWen), W'(0));
      checkOutput("rst_busy", W'(busy), W'(0));
      checkOutput("rst_done", W'(done), W'(0));
      checkOutput("rst_sram_addr", W'(sramAddr), W'(0));
      checkOutput("rst_out_addr", W'(outAddr), W'(0));
`ifdef PSUM_FEEDER_CYCCNT_EN
      checkOutput("rst_cyc_cnt", W'(cycCnt), W'(0));
`endif
      clrCnt = 0;
      validCnt = 0;
    end else begin
      if (sfpClr === 1'b1) clrCnt++;
      if (sfpIValid === 1'b1) validCnt++;
      if (sramCen === 1'b0) begin
        checkOutput("read_expected", W'(expRd.size() != 0), W'(1));
        checkOutput("busy_during_read", W'(busy), W'(1));
        if (expRd.size() != 0) checkOutput("sram_addr", W'(sramAddr), W'(expRd.pop_front()));
      end
      if (outWen === 1'b1) begin
        checkOutput("write_expected", W'(expWr.size() != 0), W'(1));
        if (expWr.size() != 0) begin
          wr = expWr.pop_front();
          checkOutput("out_addr", W'(outAddr), W'(wr.addr));
          checkOutput("out_wdata", outWdata, wr.data);
        end
      end
      if (done === 1'b1) begin
        checkOutput("done_expected", W'(expJob.size() != 0), W'(1));
        checkOutput("busy_at_done", W'(busy), W'(0));
        if (expJob.size() != 0) begin
          jb = expJob.pop_front();
          checkOutput("done_latency", W'(cycleNum - jb.startCycle), W'(jb.lat));
          checkOutput("sfp_clr_count", W'(clrCnt), W'(jb.nClr));
          checkOutput("sfp_valid_count", W'(validCnt), W'(jb.nValid));
`ifdef PSUM_FEEDER_CYCCNT_EN
          checkOutput("cyc_cnt", W'(cycCnt), W'(jb.cyc));
`endif
        end
        clrCnt = 0;
        validCnt = 0;
      end
    end
    if (endReq && !monDone) begin
      checkOutput("pending_reads", W'(expRd.size()), W'(0));
      checkOutput("pending_writes", W'(expWr.size()), W'(0));
      checkOutput("pending_jobs", W'(expJob.size()), W'(0));
      checkOutput("job_timeout", W'(timedOut), W'(0));
      monDone = 1'b1;
    end
  end

  // Queue the full expected response of one job, launch it, and wait (bounded) for done.
  task automatic applyStimulus(input logic [3:0] np, input logic [AddrBw-1:0] no, input bit cm,
                               input int midStartAfter);
    job_t         jb;
    logic [W-1:0] d;
    logic [W-1:0] w;
    int           guard;
    bit           zero;
    zero = (np == 4'd0) || (no == '0);
    dataMode = cm;
    for (int o = 0; o < int'(no); o++)
      for (int p = 0; p < int'(np); p++)
        expRd.push_back(AddrBw'(p * int'(no) + o));
    for (int o = 0; o < int'(no); o++) begin
      d = '0;
      for (int p = 0; p < int'(np); p++) begin
        w = memWord(AddrBw'(p * int'(no) + o), cm);
        for (int k = 0; k < Col; k++)
          d[k*PsumBw +: PsumBw] = d[k*PsumBw +: PsumBw] + w[k*PsumBw +: PsumBw];
      end
      if (!zero) expWr.push_back('{addr: AddrBw'(o), data: d});
    end
    jb.lat    = zero ? 1 : int'(no) * (int'(np) + 3) + 1;
    jb.nClr   = zero ? 0 : int'(no);
    jb.nValid = int'(no) * int'(np);
    jb.cyc    = zero ? 0 : int'(no) * (int'(np) + 3);
    @(posedge clk); #1;
    jb.startCycle = cycleNum;
    expJob.push_back(jb);
    start = 1'b1; numPass = np; numOut = no;
    @(posedge clk); #1;
    start = 1'b0; numPass = 4'hF; numOut = '1;
    guard = 0;
    while (done !== 1'b1 && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
      if (guard == midStartAfter) begin
        start = 1'b1; numPass = 4'd9; numOut = AddrBw'(7);
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end
    end
    if (guard >= 10000) timedOut = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(4'd2, AddrBw'(3), 1'b0, 0);
    applyStimulus(4'd1, AddrBw'(1), 1'b1, 0);
    applyStimulus(4'd0, AddrBw'(4), 1'b0, 0);
    applyStimulus(4'd3, AddrBw'(0), 1'b0, 0);

    // Abort a num_pass=4 job in its third READ cycle; only three reads and no done may appear.
    expRd.push_back(AddrBw'(0));
    expRd.push_back(AddrBw'(2));
    expRd.push_back(AddrBw'(4));
    dataMode = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; numPass = 4'd4; numOut = AddrBw'(2);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(4'd4, AddrBw'(2), 1'b0, 0);

    applyStimulus(4'd2, AddrBw'(3), 1'b0, 4);

    // Reset wins over a simultaneous start.
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; numPass = 4'd3; numOut = AddrBw'(2);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    applyStimulus(4'd3, AddrBw'(700), 1'b0, 0);

    endReq = 1'b1;
    wait (monDone);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
